lfsr_seq: RTL

//  Parametrised Fibonacci LFSR pseudo-random sequencer; next generation of the team's 2-bit seeded XOR shifter.

---
 rtl/lfsr_pkg.sv | 8 +
 rtl/lfsr_next.sv | 12 +
 rtl/lfsr_seq.sv | 68 ++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width limit, default maximal tap masks and operation encoding
package lfsr_pkg;
  localparam int LFSR_MAX_N = 32;
  localparam logic [3:0] LFSR_TAPS_4 = 4'b1100;
  localparam logic [7:0] LFSR_TAPS_8 = 8'b1011_1000;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  typedef enum logic [1:0] {LFSR_HOLD, LFSR_LOAD, LFSR_STEP} lfsr_op_t;
endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: combinational Fibonacci LFSR next state and feedback bit
module lfsr_next import lfsr_pkg::*; #(
  parameter int N = 4,
  parameter logic [N-1:0] TAPS = LFSR_TAPS_4
)(
  input logic [N-1:0] state,
  output logic [N-1:0] next,
  output logic fb
);
  assign fb = ^(state & TAPS);
  assign next = {state[N-2:0], fb};
endmodule

// File: rtl/lfsr_seq.sv
// lfsr_seq: seeded Fibonacci LFSR sequencer with lock-up recovery; LFSR_PERIOD_EN adds start/steps/period_done tracking
module lfsr_seq import lfsr_pkg::*; #(
  parameter int N = 4,
  parameter logic [N-1:0] TAPS = LFSR_TAPS_4,
  parameter logic [N-1:0] RESET_SEED = {{(N-1){1'b0}}, 1'b1}
)(
  input logic clk,
  input logic rst,
  input logic ena,
  input logic load,
  input logic [N-1:0] seed,
  output logic out,
  output logic [N-1:0] state,
  output logic zero_seed,
  output logic period_done,
  output logic [N-1:0] steps
);
  lfsr_op_t op;
  logic [N-1:0] state_q, state_d, next, seed_eff;
  logic out_q, out_d, zero_q, zero_d, fb_unused;
  lfsr_next #(.N(N), .TAPS(TAPS)) u_next (.state(state_q), .next(next), .fb(fb_unused));
  always_comb begin
    op = load ? LFSR_LOAD : ena ? LFSR_STEP : LFSR_HOLD;
    seed_eff = |seed ? seed : RESET_SEED;
    state_d = op == LFSR_LOAD ? seed_eff : op == LFSR_STEP ? (|state_q ? next : RESET_SEED) : state_q;
    out_d = op == LFSR_STEP ? state_q[N-1] : out_q;
    zero_d = op == LFSR_LOAD && !(|seed);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_SEED;
      out_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      zero_q <= zero_d;
    end
  end
  assign state = state_q;
  assign out = out_q;
  assign zero_seed = zero_q;
`ifdef LFSR_PERIOD_EN
  logic [N-1:0] start_q, start_d, steps_q, steps_d;
  logic pd_q, pd_d;
  always_comb begin
    start_d = op == LFSR_LOAD ? seed_eff : start_q;
    pd_d = op == LFSR_STEP && state_d == start_q;
    steps_d = op == LFSR_LOAD || pd_d ? '0 : op == LFSR_STEP ? steps_q + 1'b1 : steps_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= RESET_SEED;
      steps_q <= '0;
      pd_q <= 1'b0;
    end else begin
      start_q <= start_d;
      steps_q <= steps_d;
      pd_q <= pd_d;
    end
  end
  assign steps = steps_q;
  assign period_done = pd_q;
`else
  assign steps = '0;
  assign period_done = 1'b0;
`endif
endmodule
